axis_pattern_gen: RTL and testbench

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

---
 rtl/axis_pattern_gen.sv | 203 ++++++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen.sv
// AXI-Stream test-pattern generator: emits runs of packets with a selectable data
// pattern, optional inter-packet gap, and abort that only takes effect at packet boundaries.
module axis_pattern_gen #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int LEN_WIDTH       = 16
) (
   input  logic                       i_axis_clk,
   input  logic                       i_axis_rst,
   input  logic                       i_start,
   input  logic                       i_abort,
   input  logic [1:0]                 i_pattern_sel,
   input  logic [AXIS_DATA_WIDTH-1:0] i_seed,
   input  logic [LEN_WIDTH-1:0]       i_packet_len,
   input  logic [LEN_WIDTH-1:0]       i_packet_count,
   input  logic [LEN_WIDTH-1:0]       i_gap,
   output logic                       o_axis_out_tuser,
   output logic                       o_axis_out_tvalid,
   input  logic                       i_axis_out_tready,
   output logic                       o_axis_out_tlast,
   output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [31:0]                o_packets_sent,
   output logic [1:0]                 o_state
);

   // Stream handshake: a beat moves only when tvalid and tready are both high; while
   // tvalid=1 and tready=0, tdata/tuser/tlast hold and tvalid stays high.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [1:0]                 sel_q, sel_d;
   logic [AXIS_DATA_WIDTH-1:0] seed_q, seed_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [LEN_WIDTH-1:0]       count_q, count_d;
   logic [LEN_WIDTH-1:0]       gap_q, gap_d;
   logic [LEN_WIDTH-1:0]       idx_q, idx_d;
   logic [AXIS_DATA_WIDTH-1:0] gbeat_q, gbeat_d;
   logic [LEN_WIDTH-1:0]       pkt_num_q, pkt_num_d;
   logic [7:0]                 pkt_lo_q, pkt_lo_d;
   logic [LEN_WIDTH-1:0]       gap_cnt_q, gap_cnt_d;
   logic                       abort_q, abort_d;
   logic                       done_q, done_d;
   logic [31:0]                sent_q, sent_d;

   logic                       tvalid;
   logic                       beat_hs;
   logic                       last_beat;
   logic                       abort_now;
   logic                       more_pkts;
   logic [LEN_WIDTH:0]         pkt_next_ext;
   logic [LEN_WIDTH+7:0]       p2_cat;
   logic [AXIS_DATA_WIDTH-1:0] pattern;

   assign tvalid       = (state_q == S_SEND);
   assign beat_hs      = tvalid & i_axis_out_tready;
   assign last_beat    = (idx_q == (len_q - LEN_WIDTH'(1)));
   assign abort_now    = abort_q | i_abort;
   assign pkt_next_ext = {1'b0, pkt_num_q} + (LEN_WIDTH+1)'(1);
   // A zero packet count means run until aborted.
   assign more_pkts    = (count_q == '0) || (pkt_next_ext < {1'b0, count_q});
   assign p2_cat       = {pkt_lo_q, idx_q};

   always_comb begin
      pattern = seed_q;
      case (sel_q)
         2'd0:    pattern = seed_q + AXIS_DATA_WIDTH'(idx_q);
         2'd1:    pattern = seed_q + gbeat_q;
         2'd2:    pattern = AXIS_DATA_WIDTH'(p2_cat);
         default: pattern = seed_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      seed_d    = seed_q;
      len_d     = len_q;
      count_d   = count_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      gbeat_d   = gbeat_q;
      pkt_num_d = pkt_num_q;
      pkt_lo_d  = pkt_lo_q;
      gap_cnt_d = gap_cnt_q;
      abort_d   = abort_q;
      done_d    = 1'b0;
      sent_d    = sent_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d   = S_SEND;
               sel_d     = i_pattern_sel;
               seed_d    = i_seed;
               len_d     = (i_packet_len == '0) ? LEN_WIDTH'(1) : i_packet_len;
               count_d   = i_packet_count;
               gap_d     = i_gap;
               idx_d     = '0;
               gbeat_d   = '0;
               pkt_num_d = '0;
               pkt_lo_d  = '0;
               gap_cnt_d = '0;
               // Abort coinciding with start limits the run to one packet.
               abort_d   = i_abort;
               sent_d    = '0;
            end
         end

         S_SEND: begin
            if (i_abort) begin
               abort_d = 1'b1;
            end
            if (beat_hs) begin
               gbeat_d = gbeat_q + AXIS_DATA_WIDTH'(1);
               if (last_beat) begin
                  idx_d     = '0;
                  pkt_num_d = pkt_num_q + LEN_WIDTH'(1);
                  pkt_lo_d  = pkt_lo_q + 8'd1;
                  sent_d    = (sent_q == 32'hFFFF_FFFF) ? sent_q : sent_q + 32'd1;
                  if (abort_now || !more_pkts) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     abort_d = 1'b0;
                  end else if (gap_q != '0) begin
                     state_d   = S_GAP;
                     gap_cnt_d = gap_q;
                  end
               end else begin
                  idx_d = idx_q + LEN_WIDTH'(1);
               end
            end
         end

         S_GAP: begin
            if (abort_now) begin
               state_d   = S_IDLE;
               done_d    = 1'b1;
               abort_d   = 1'b0;
               gap_cnt_d = '0;
            end else if (gap_cnt_q <= LEN_WIDTH'(1)) begin
               state_d   = S_SEND;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q - LEN_WIDTH'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
      if (!i_axis_rst) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         seed_q    <= '0;
         len_q     <= '0;
         count_q   <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         gbeat_q   <= '0;
         pkt_num_q <= '0;
         pkt_lo_q  <= '0;
         gap_cnt_q <= '0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         seed_q    <= seed_d;
         len_q     <= len_d;
         count_q   <= count_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         gbeat_q   <= gbeat_d;
         pkt_num_q <= pkt_num_d;
         pkt_lo_q  <= pkt_lo_d;
         gap_cnt_q <= gap_cnt_d;
         abort_q   <= abort_d;
         done_q    <= done_d;
         sent_q    <= sent_d;
      end
   end

   // Outputs are gated by tvalid so the bus reads all-zero whenever nothing is offered.
   assign o_axis_out_tvalid = tvalid;
   assign o_axis_out_tuser  = tvalid & (idx_q == '0);
   assign o_axis_out_tlast  = tvalid & last_beat;
   assign o_axis_out_tdata  = tvalid ? pattern : '0;
   assign o_busy            = (state_q != S_IDLE);
   assign o_done            = done_q;
   assign o_packets_sent    = sent_q;
   assign o_state           = state_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: scoreboard of expected beats plus
// per-scenario tasks covering reset, patterns, backpressure, gap, abort and ignored start.
module tb_axis_pattern_gen;

   localparam int DW = 32;
   localparam int LW = 16;
   localparam int EW = DW + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    pattern_sel = '0;
   logic [DW-1:0] seed = '0;
   logic [LW-1:0] packet_len = '0;
   logic [LW-1:0] packet_count = '0;
   logic [LW-1:0] gap = '0;
   logic          tuser;
   logic          tvalid;
   logic          tready = 1'b1;
   logic          tlast;
   logic [DW-1:0] tdata;
   logic          busy;
   logic          done;
   logic [31:0]   packets_sent;
   logic [1:0]    state_dbg;

   logic [EW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;
   bit            mon_en = 1'b1;
   logic          prev_stall = 1'b0;
   logic [EW-1:0] prev_beat = '0;

   axis_pattern_gen #(.AXIS_DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .i_axis_clk        (clk),
      .i_axis_rst        (rst_n),
      .i_start           (start),
      .i_abort           (abort),
      .i_pattern_sel     (pattern_sel),
      .i_seed            (seed),
      .i_packet_len      (packet_len),
      .i_packet_count    (packet_count),
      .i_gap             (gap),
      .o_axis_out_tuser  (tuser),
      .o_axis_out_tvalid (tvalid),
      .i_axis_out_tready (tready),
      .o_axis_out_tlast  (tlast),
      .o_axis_out_tdata  (tdata),
      .o_busy            (busy),
      .o_done            (done),
      .o_packets_sent    (packets_sent),
      .o_state           (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: pops one expected beat per handshake, checks stall stability.
   always @(negedge clk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] want;
      got = {tuser, tlast, tdata};
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (done === 1'b1) done_cnt++;
         if (mon_en) begin
            if (prev_stall) begin
               checks++;
               if (tvalid !== 1'b1 || got !== prev_beat) begin
                  errors++;
                  $display("FAIL stall_hold got valid=%0b beat=%h want valid=1 beat=%h", tvalid, got, prev_beat);
               end
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat got %h want none", got);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) begin
                     errors++;
                     $display("FAIL beat got user/last/data=%h want %h", got, want);
                  end
               end
            end
         end
         prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
         prev_beat  = got;
      end
   end

   task automatic push_expected(input logic [1:0] sel, input logic [DW-1:0] sd, input int len, input int npkts);
      int l;
      int g;
      logic [DW-1:0] d;
      l = (len == 0) ? 1 : len;
      g = 0;
      for (int p = 0; p < npkts; p++) begin
         for (int i = 0; i < l; i++) begin
            case (sel)
               2'd0:    d = sd + DW'(i);
               2'd1:    d = sd + DW'(g);
               2'd2:    d = (DW'(p & 255) << 16) | DW'(i & 32'hFFFF);
               default: d = sd;
            endcase
            exp_q.push_back({(i == 0), (i == l - 1), d});
            g++;
         end
      end
   endtask

   task automatic start_run(input logic [1:0] sel, input logic [DW-1:0] sd, input logic [LW-1:0] len,
                            input logic [LW-1:0] cnt, input logic [LW-1:0] gp, input bit with_abort);
      @(posedge clk); #1;
      pattern_sel  = sel;
      seed         = sd;
      packet_len   = len;
      packet_count = cnt;
      gap          = gp;
      start        = 1'b1;
      abort        = with_abort;
      @(posedge clk); #1;
      start        = 1'b0;
      abort        = 1'b0;
      pattern_sel  = 2'($urandom_range(0, 3));
      seed         = $urandom;
      packet_len   = LW'($urandom_range(1, 9));
      packet_count = LW'($urandom_range(1, 9));
      gap          = LW'($urandom_range(0, 4));
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(posedge clk); #1;
         if (rnd) tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_at_done got %0b want 0", busy);
            end
         end
      end
      tready = 1'b1;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout got no done want done within %0d cycles", budget);
      end
   endtask

   task automatic check_end(input string name, input logic [31:0] want_sent);
      repeat (3) @(negedge clk);
      checks++;
      if (packets_sent !== want_sent) begin
         errors++;
         $display("FAIL %s packets_sent got %0d want %0d", name, packets_sent, want_sent);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s missing_beats got %0d left want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tvalid, tuser, tlast, busy, done} !== 5'b0 || tdata !== '0 || packets_sent !== '0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%0b u=%0b l=%0b busy=%0b done=%0b data=%h sent=%0d st=%0d want all 0",
                  tvalid, tuser, tlast, busy, done, tdata, packets_sent, state_dbg);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== '0) begin
         errors++;
         $display("FAIL idle_after_release got v=%0b busy=%0b data=%h want 0", tvalid, busy, tdata);
      end
   endtask

   task automatic test_basic();
      done_cnt = 0;
      tready   = 1'b1;
      push_expected(2'd0, 32'h10, 4, 2);
      start_run(2'd0, 32'h10, 16'd4, 16'd2, 16'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (tvalid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_valid_latency got v=%0b busy=%0b want 1 1", tvalid, busy);
      end
      wait_done(100, 1'b0);
      check_end("basic", 32'd2);
   endtask

   task automatic test_back_to_back();
      done_cnt = 0;
      push_expected(2'd3, 32'h7, 2, 1);
      start_run(2'd3, 32'h7, 16'd2, 16'd1, 16'd0, 1'b0);
      wait_done(100, 1'b0);
      push_expected(2'd0, 32'h20, 2, 1);
      start_run(2'd0, 32'h20, 16'd2, 16'd1, 16'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (packets_sent !== 32'd0) begin
         errors++;
         $display("FAIL sent_clear_on_start got %0d want 0", packets_sent);
      end
      done_cnt = 0;
      wait_done(100, 1'b0);
      check_end("back_to_back", 32'd1);
   endtask

   task automatic test_backpressure();
      done_cnt = 0;
      push_expected(2'd1, 32'h0, 3, 4);
      start_run(2'd1, 32'h0, 16'd3, 16'd4, 16'd0, 1'b0);
      wait_done(600, 1'b1);
      check_end("backpressure", 32'd4);
   endtask

   task automatic test_gap();
      int beat_cyc[$];
      int cyc;
      bit seen;
      done_cnt = 0;
      cyc  = 0;
      seen = 1'b0;
      tready = 1'b1;
      push_expected(2'd3, 32'hA5, 0, 3);
      start_run(2'd3, 32'hA5, 16'd0, 16'd3, 16'd2, 1'b0);
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (tvalid === 1'b1) beat_cyc.push_back(cyc);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (beat_cyc.size() != 3) begin
         errors++;
         $display("FAIL gap_beat_count got %0d want 3", beat_cyc.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (beat_cyc[k] - beat_cyc[k-1] != 3) begin
               errors++;
               $display("FAIL gap_spacing got %0d idle want 2", beat_cyc[k] - beat_cyc[k-1] - 1);
            end
         end
      end
      check_end("gap", 32'd3);
   endtask

   task automatic test_abort();
      int nb;
      done_cnt = 0;
      nb = 0;
      tready = 1'b1;
      push_expected(2'd0, 32'h100, 5, 3);
      start_run(2'd0, 32'h100, 16'd5, 16'd0, 16'd0, 1'b0);
      for (int c = 0; c < 200 && nb < 13; c++) begin
         @(negedge clk);
         if (tvalid === 1'b1 && tready === 1'b1) nb++;
      end
      checks++;
      if (nb != 13) begin
         errors++;
         $display("FAIL abort_reach_beat got %0d beats want 13", nb);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done(100, 1'b0);
      check_end("abort", 32'd3);
   endtask

   task automatic test_reset_mid();
      mon_en = 1'b0;
      tready = 1'b1;
      start_run(2'd0, 32'h40, 16'd5, 16'd1, 16'd0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      tready = 1'b0;
      @(negedge clk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h42) begin
         errors++;
         $display("FAIL pre_reset_beat got v=%0b data=%h want 1 00000042", tvalid, tdata);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tvalid, tuser, tlast, busy, done} !== 5'b0 || tdata !== '0 || packets_sent !== '0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got v=%0b u=%0b l=%0b busy=%0b done=%0b data=%h sent=%0d want all 0",
                  tvalid, tuser, tlast, busy, done, tdata, packets_sent);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      tready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (tvalid !== 1'b0 || tdata !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL quiet_after_reset got v=%0b data=%h busy=%0b want 0", tvalid, tdata, busy);
         end
      end
      exp_q.delete();
      mon_en   = 1'b1;
      done_cnt = 0;
      push_expected(2'd0, 32'h40, 3, 1);
      start_run(2'd0, 32'h40, 16'd3, 16'd1, 16'd0, 1'b0);
      wait_done(100, 1'b0);
      check_end("reset_restart", 32'd1);
   endtask

   task automatic test_ignored_start();
      done_cnt = 0;
      tready = 1'b1;
      push_expected(2'd2, 32'h0, 4, 2);
      start_run(2'd2, 32'h0, 16'd4, 16'd2, 16'd1, 1'b0);
      start        = 1'b1;
      pattern_sel  = 2'd0;
      packet_len   = 16'd9;
      packet_count = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (packets_sent !== 32'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ignored_start got sent=%0d busy=%0b want 0 1", packets_sent, busy);
      end
      wait_done(100, 1'b0);
      check_end("ignored_start", 32'd2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_gap();
      test_abort();
      test_reset_mid();
      test_ignored_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
